// File: rtl/jtdd_dwnld_router.sv
// ROM download router: splits the ioctl byte stream into SDRAM region writes
// (16-bit words with byte mask and ready handshake) and one-hot PROM strobes.
module jtdd_dwnld_router #(
    parameter int                     AW         = 22,
    parameter int                     NREG       = 4,
    parameter logic [NREG*AW-1:0]     BASE       = {22'h28000, 22'h18000, 22'h8000, 22'h0},
    parameter logic [NREG*AW-1:0]     OFFSET     = {22'h14000, 22'hC000, 22'h4000, 22'h0},
    parameter logic [AW-1:0]          PROM_START = 22'h38000,
    parameter int                     PROM_AW    = 8,
    parameter int                     PROM_W     = 4,
    parameter int                     HEADER     = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              downloading,
    input  logic [AW-1:0]     ioctl_addr,
    input  logic [7:0]        ioctl_data,
    input  logic              ioctl_wr,
    output logic [AW-1:0]     prog_addr,
    output logic [7:0]        prog_data,
    output logic [1:0]        prog_mask,
    output logic              prog_we,
    input  logic              prog_rdy,
    output logic [PROM_W-1:0] prom_we,
    output logic              overflow,
    output logic              done
);

    typedef struct packed {
        logic              prom;
        logic [AW-1:0]     addr;
        logic [7:0]        data;
        logic [1:0]        mask;
        logic [PROM_W-1:0] pwe;
    } ent_t;

    typedef enum logic {IDLE, REQ} state_t;

    state_t            state_q;
    ent_t              skid_q;
    logic              skid_v_q;
    logic [AW-1:0]     prog_addr_q;
    logic [7:0]        prog_data_q;
    logic [1:0]        prog_mask_q;
    logic              prog_we_q;
    logic [PROM_W-1:0] prom_we_q;
    logic              overflow_q, done_q, pend_q, dl_q;

    logic              hdr_drop;
    logic [AW-1:0]     eff, rel, chan, rbase, roff;
    ent_t              in_e, src;
    logic              in_v, free, take_skid, src_v, load_skid, lost;
    logic              skid_v_d, idle_next, fall, rise;
    logic              done_d, pend_d, overflow_d;

    generate
        if (HEADER > 0) begin : g_hdr
            assign hdr_drop = ioctl_addr < AW'(HEADER);
        end else begin : g_nohdr
            assign hdr_drop = 1'b0;
        end
    endgenerate

    // Decode the incoming byte into a ready-to-issue entry
    always_comb begin
        eff   = ioctl_addr - AW'(HEADER);
        rel   = eff - PROM_START;
        chan  = rel >> PROM_AW;
        rbase = BASE[AW-1:0];
        roff  = OFFSET[AW-1:0];
        for (int i = 1; i < NREG; i++) begin
            if (eff >= BASE[i*AW +: AW]) begin
                rbase = BASE[i*AW +: AW];
                roff  = OFFSET[i*AW +: AW];
            end
        end
        in_e      = '0;
        in_e.data = ioctl_data;
        if (eff >= PROM_START) begin
            in_e.prom = 1'b1;
            in_e.addr = AW'(rel[PROM_AW-1:0]);
            in_e.mask = 2'b11;
            in_e.pwe  = PROM_W'(1) << chan;
            in_v      = chan < AW'(PROM_W);
        end else begin
            in_e.addr = ((eff - rbase) >> 1) + roff;
            in_e.mask = eff[0] ? 2'b01 : 2'b10;
            in_v      = 1'b1;
        end
        in_v = in_v & ioctl_wr & downloading & ~hdr_drop;
    end

    // The output slot is free when idle or when the pending request is accepted;
    // a full skid always has priority over the new byte to keep ordering.
    always_comb begin
        free       = (state_q == IDLE) | prog_rdy;
        take_skid  = free & skid_v_q;
        src        = take_skid ? skid_q : in_e;
        src_v      = free & (take_skid | in_v);
        load_skid  = in_v & (free ? skid_v_q : ~skid_v_q);
        lost       = in_v & ~free & skid_v_q;
        skid_v_d   = free ? (skid_v_q & in_v) : (skid_v_q | in_v);
        idle_next  = free & (~src_v | src.prom);
        fall       = dl_q & ~downloading;
        rise       = ~dl_q & downloading;
        done_d     = (pend_q | fall) & idle_next & ~skid_v_d;
        pend_d     = ~rise & (pend_q | fall) & ~done_d;
        overflow_d = (overflow_q & ~rise) | lost;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            skid_q      <= '0;
            skid_v_q    <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
            prog_mask_q <= 2'b11;
            prog_we_q   <= 1'b0;
            prom_we_q   <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            pend_q      <= 1'b0;
            dl_q        <= 1'b0;
        end else begin
            dl_q       <= downloading;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            pend_q     <= pend_d;
            skid_v_q   <= skid_v_d;
            prom_we_q  <= '0;
            if (load_skid) skid_q <= in_e;
            if (free) begin
                if (src_v) begin
                    prog_addr_q <= src.addr;
                    prog_data_q <= src.data;
                    if (src.prom) begin
                        prom_we_q <= src.pwe;
                        prog_we_q <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        prog_mask_q <= src.mask;
                        prog_we_q   <= 1'b1;
                        state_q     <= REQ;
                    end
                end else begin
                    prog_we_q <= 1'b0;
                    state_q   <= IDLE;
                end
            end
        end
    end

    assign prog_addr = prog_addr_q;
    assign prog_data = prog_data_q;
    assign prog_mask = prog_mask_q;
    assign prog_we   = prog_we_q;
    assign prom_we   = prom_we_q;
    assign overflow  = overflow_q;
    assign done      = done_q;

endmodule

// File: tb/tb_jtdd_dwnld_router.sv
// Bench for jtdd_dwnld_router: directed scenarios plus randomized traffic
// checked against an address-map reference model.
module tb_jtdd_dwnld_router;

    typedef struct packed {
        bit          prom;
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
        logic [3:0]  pwe;
    } ent_t;

    localparam int unsigned MB[4]  = '{32'h0, 32'h8000, 32'h18000, 32'h28000};
    localparam int unsigned MO[4]  = '{32'h0, 32'h4000, 32'hC000, 32'h14000};
    localparam int unsigned MPROM  = 32'h38000;

    logic        clk = 1'b0, rst_n = 1'b0, downloading = 1'b0, ioctl_wr = 1'b0, prog_rdy = 1'b0;
    logic [21:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic [21:0] prog_addr, h_addr;
    logic [7:0]  prog_data, h_data;
    logic [1:0]  prog_mask, h_mask;
    logic        prog_we, h_we, overflow, h_ovf, done, h_done;
    logic [3:0]  prom_we, h_prom;

    int checks = 0, passed = 0;
    ent_t exp_q[$], obs_q[$];
    bit mon_en = 1'b0;

    jtdd_dwnld_router dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading), .ioctl_addr(ioctl_addr),
        .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_mask(prog_mask), .prog_we(prog_we), .prog_rdy(prog_rdy), .prom_we(prom_we),
        .overflow(overflow), .done(done)
    );

    jtdd_dwnld_router #(.HEADER(32'h40)) dut_h (
        .clk(clk), .rst_n(rst_n), .downloading(downloading), .ioctl_addr(ioctl_addr),
        .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .prog_addr(h_addr), .prog_data(h_data),
        .prog_mask(h_mask), .prog_we(h_we), .prog_rdy(prog_rdy), .prom_we(h_prom),
        .overflow(h_ovf), .done(h_done)
    );

    always #5 clk = ~clk;

    // Observed write stream: SDRAM acceptances and PROM strobes, in order
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (prog_we && prog_rdy) obs_q.push_back({1'b0, prog_addr, prog_data, prog_mask, 4'h0});
            if (|prom_we)            obs_q.push_back({1'b1, prog_addr, prog_data, 2'b11, prom_we});
        end
    end

    function automatic void model(input logic [21:0] a, input logic [7:0] d, input int unsigned hdr,
                                  output bit drop, output ent_t e);
        int unsigned eff, rel, k, sel;
        e    = '0;
        drop = 1'b0;
        e.data = d;
        if (a < hdr) begin
            drop = 1'b1;
            return;
        end
        eff = a - hdr;
        if (eff >= MPROM) begin
            rel = eff - MPROM;
            k   = rel / 256;
            if (k >= 4) drop = 1'b1;
            e.prom = 1'b1;
            e.addr = 22'(rel % 256);
            e.mask = 2'b11;
            e.pwe  = 4'(1 << (k % 4));
        end else begin
            sel = 0;
            for (int i = 0; i < 4; i++) if (eff >= MB[i]) sel = i;
            e.addr = 22'((eff - MB[sel]) / 2 + MO[sel]);
            e.mask = (eff % 2 == 1) ? 2'b01 : 2'b10;
        end
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr_byte(input logic [21:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        @(posedge clk); #1;
        ioctl_wr   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #12;
        checks++; if (prog_we !== 1'b0)    $display("FAIL reset_we got %0b want 0", prog_we); else passed++;
        checks++; if (prog_mask !== 2'b11) $display("FAIL reset_mask got %0b want 11", prog_mask); else passed++;
        checks++; if (prom_we !== 4'h0)    $display("FAIL reset_prom got %0b want 0", prom_we); else passed++;
        checks++; if (prog_addr !== 22'h0) $display("FAIL reset_addr got %0h want 0", prog_addr); else passed++;
        checks++; if ({overflow, done} !== 2'b00) $display("FAIL reset_flags got %0b want 00", {overflow, done}); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        downloading = 1'b1;
        tick();
    endtask

    task automatic test_sdram_basic();
        prog_rdy = 1'b1;
        wr_byte(22'h0, 8'h11);
        checks++; if ({prog_we, prog_addr, prog_mask, prog_data} !== {1'b1, 22'h0, 2'b10, 8'h11})
            $display("FAIL sdram_lo got we=%0b a=%0h m=%0b d=%0h want 1/0/10/11", prog_we, prog_addr, prog_mask, prog_data);
        else passed++;
        wr_byte(22'h1, 8'h22);
        checks++; if ({prog_we, prog_addr, prog_mask, prog_data} !== {1'b1, 22'h0, 2'b01, 8'h22})
            $display("FAIL sdram_hi got we=%0b a=%0h m=%0b d=%0h want 1/0/01/22", prog_we, prog_addr, prog_mask, prog_data);
        else passed++;
        tick();
        checks++; if (prog_we !== 1'b0) $display("FAIL sdram_release got %0b want 0", prog_we); else passed++;
    endtask

    task automatic test_regions();
        wr_byte(22'h8003, 8'hA5);
        checks++; if ({prog_we, prog_addr, prog_mask, prog_data} !== {1'b1, 22'h4001, 2'b01, 8'hA5})
            $display("FAIL region1 got we=%0b a=%0h m=%0b d=%0h want 1/4001/01/a5", prog_we, prog_addr, prog_mask, prog_data);
        else passed++;
        tick();
        wr_byte(22'h28000, 8'h3C);
        checks++; if ({prog_addr, prog_mask} !== {22'h14000, 2'b10})
            $display("FAIL region3 got a=%0h m=%0b want 14000/10", prog_addr, prog_mask);
        else passed++;
        tick();
    endtask

    task automatic test_prom();
        wr_byte(22'h38105, 8'h5C);
        checks++; if ({prom_we, prog_addr, prog_data, prog_we} !== {4'b0010, 22'h5, 8'h5C, 1'b0})
            $display("FAIL prom_wr got pw=%0b a=%0h d=%0h we=%0b want 0010/5/5c/0", prom_we, prog_addr, prog_data, prog_we);
        else passed++;
        tick();
        checks++; if (prom_we !== 4'h0) $display("FAIL prom_pulse got %0b want 0", prom_we); else passed++;
        wr_byte(22'h38400, 8'h99);
        checks++; if ({prom_we, prog_we, overflow} !== 6'b0)
            $display("FAIL prom_oor got pw=%0b we=%0b ovf=%0b want 0", prom_we, prog_we, overflow);
        else passed++;
    endtask

    task automatic test_overflow();
        prog_rdy = 1'b0;
        wr_byte(22'h100, 8'hB1);
        repeat (3) tick();
        wr_byte(22'h102, 8'hB2);
        repeat (3) tick();
        wr_byte(22'h104, 8'hB3);
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_set got %0b want 1", overflow); else passed++;
        checks++; if ({prog_we, prog_addr, prog_data} !== {1'b1, 22'h80, 8'hB1})
            $display("FAIL ovf_hold got we=%0b a=%0h d=%0h want 1/80/b1", prog_we, prog_addr, prog_data);
        else passed++;
        tick();
        prog_rdy = 1'b1;
        tick();
        checks++; if ({prog_we, prog_addr, prog_data, prog_mask} !== {1'b1, 22'h81, 8'hB2, 2'b10})
            $display("FAIL ovf_skid got we=%0b a=%0h d=%0h m=%0b want 1/81/b2/10", prog_we, prog_addr, prog_data, prog_mask);
        else passed++;
        tick();
        checks++; if (prog_we !== 1'b0) $display("FAIL ovf_drain got %0b want 0", prog_we); else passed++;
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %0b want 1", overflow); else passed++;
        downloading = 1'b0;
        repeat (2) tick();
        downloading = 1'b1;
        tick();
        checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %0b want 0", overflow); else passed++;
    endtask

    task automatic test_done();
        int n;
        prog_rdy = 1'b0;
        wr_byte(22'h200, 8'h33);
        downloading = 1'b0;
        n = 0;
        repeat (5) begin
            tick();
            if (done) n++;
        end
        checks++; if (n !== 0) $display("FAIL done_early got %0d pulses want 0", n); else passed++;
        prog_rdy = 1'b1;
        tick();
        checks++; if ({done, prog_we} !== 2'b10) $display("FAIL done_pulse got done=%0b we=%0b want 1/0", done, prog_we); else passed++;
        n = 0;
        repeat (10) begin
            tick();
            if (done) n++;
        end
        checks++; if (n !== 0) $display("FAIL done_once got %0d extra pulses want 0", n); else passed++;
        downloading = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        prog_rdy = 1'b0;
        wr_byte(22'h300, 8'h44);
        downloading = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({prog_we, prog_mask} !== 3'b011)
            $display("FAIL rstmid got we=%0b m=%0b want 0/11", prog_we, prog_mask);
        else passed++;
        tick();
        rst_n = 1'b1;
        n = 0;
        repeat (10) begin
            prog_rdy = 1'b1;
            tick();
            if (done) n++;
        end
        checks++; if (n !== 0) $display("FAIL rstmid_done got %0d pulses want 0", n); else passed++;
        downloading = 1'b1;
        tick();
    endtask

    task automatic test_header();
        prog_rdy = 1'b1;
        wr_byte(22'h3F, 8'h77);
        checks++; if ({h_we, h_prom} !== 5'b0) $display("FAIL hdr_drop got we=%0b pw=%0b want 0", h_we, h_prom); else passed++;
        tick();
        wr_byte(22'h40, 8'h88);
        checks++; if ({h_we, h_addr, h_mask, h_data} !== {1'b1, 22'h0, 2'b10, 8'h88})
            $display("FAIL hdr_first got we=%0b a=%0h m=%0b d=%0h want 1/0/10/88", h_we, h_addr, h_mask, h_data);
        else passed++;
        tick();
    endtask

    task automatic test_random();
        bit   drop;
        ent_t e;
        logic [21:0] a;
        logic [7:0]  d;
        int   c, nb;
        do_reset();
        downloading = 1'b1;
        tick();
        obs_q.delete();
        exp_q.delete();
        mon_en = 1'b1;
        for (int it = 0; it < 60; it++) begin
            nb = $urandom_range(1, 2);
            for (int b = 0; b < nb; b++) begin
                a = 22'($urandom_range(0, 32'h38500));
                d = 8'($urandom);
                model(a, d, 0, drop, e);
                if (!drop) exp_q.push_back(e);
                ioctl_addr = a;
                ioctl_data = d;
                ioctl_wr   = 1'b1;
                prog_rdy   = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                ioctl_wr   = 1'b0;
            end
            c = 0;
            while (prog_we && c < 200) begin
                prog_rdy = 1'($urandom_range(0, 1));
                tick();
                c++;
            end
            checks++; if (prog_we !== 1'b0) $display("FAIL rnd_drain_timeout it=%0d we=%0b want 0", it, prog_we); else passed++;
            prog_rdy = 1'b0;
            repeat (2) tick();
        end
        mon_en = 1'b0;
        checks++; if (obs_q.size() !== exp_q.size())
            $display("FAIL rnd_count got %0d writes want %0d", obs_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i])
                $display("FAIL rnd_write[%0d] got %0h want %0h", i, obs_q[i], exp_q[i]);
            else passed++;
        end
        checks++; if (overflow !== 1'b0) $display("FAIL rnd_ovf got %0b want 0", overflow); else passed++;
    endtask

    initial begin
        test_reset();
        test_sdram_basic();
        test_regions();
        test_prom();
        test_overflow();
        test_done();
        test_reset_mid();
        test_header();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
